// File: rtl/sqrt_fsm.sv
// Multi-cycle IEEE-754 single-precision square root, one restoring root bit per clock.
// Define SQRT_ROUND_NEAREST_EN to compute a guard bit and round to nearest instead of truncating.
module sqrt_fsm #(
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic        r_i,
    output logic [31:0] res,
    output logic        err,
    output logic        r_o
);

`ifdef SQRT_ROUND_NEAREST_EN
    localparam int unsigned ITERS = 25;
`else
    localparam int unsigned ITERS = 24;
`endif
    localparam int unsigned RAD_W = 2 * ITERS;
    localparam int unsigned REM_W = 28;
    localparam int unsigned TRL_W = REM_W + 1;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, PACK} state_t;

    state_t             state, state_next;
    logic [31:0]        xr, xr_next;
    logic [RAD_W-1:0]   rad, rad_next;
    logic [ITERS-1:0]   q, q_next;
    logic [REM_W-1:0]   rem, rem_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [7:0]         exp_r, exp_next;
    logic               spec, spec_next;
    logic [31:0]        spec_res, spec_res_next;
    logic               spec_err, spec_err_next;
    logic [31:0]        res_next;
    logic               err_next;
    logic               r_o_next;

    logic [7:0]         e;
    logic [22:0]        m;
    logic               s;
    logic [23:0]        sig;
    logic [REM_W-1:0]   sh;
    logic [TRL_W-1:0]   trial;
`ifdef SQRT_ROUND_NEAREST_EN
    logic [23:0]        rsum;
    logic [7:0]         exp_inc;
`endif

    assign e = xr[30:23];
    assign m = xr[22:0];
    assign s = xr[31];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            xr       <= '0;
            rad      <= '0;
            q        <= '0;
            rem      <= '0;
            cnt      <= '0;
            exp_r    <= '0;
            spec     <= 1'b0;
            spec_res <= '0;
            spec_err <= 1'b0;
            res      <= '0;
            err      <= 1'b0;
            r_o      <= 1'b0;
        end else begin
            state    <= state_next;
            xr       <= xr_next;
            rad      <= rad_next;
            q        <= q_next;
            rem      <= rem_next;
            cnt      <= cnt_next;
            exp_r    <= exp_next;
            spec     <= spec_next;
            spec_res <= spec_res_next;
            spec_err <= spec_err_next;
            res      <= res_next;
            err      <= err_next;
            r_o      <= r_o_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next    = state;
        xr_next       = xr;
        rad_next      = rad;
        q_next        = q;
        rem_next      = rem;
        cnt_next      = cnt;
        exp_next      = exp_r;
        spec_next     = spec;
        spec_res_next = spec_res;
        spec_err_next = spec_err;
        res_next      = res;
        err_next      = err;
        r_o_next      = 1'b0;
        sig           = {1'b1, m};
        sh            = {rem[REM_W-3:0], rad[RAD_W-1 -: 2]};
        trial         = {1'b0, sh} - TRL_W'({q, 2'b01});
`ifdef SQRT_ROUND_NEAREST_EN
        rsum          = 24'(q[ITERS-2:1]) + 24'(q[0]);
        exp_inc       = 8'(exp_r + 8'd1);
`endif

        case (state)
            IDLE: begin
                if (r_i) begin
                    xr_next    = x;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                spec_next     = 1'b1;
                spec_err_next = 1'b0;
                state_next    = PACK;
                if (e == 8'd0) begin
                    spec_res_next = {s, 31'b0};
                end else if (e == 8'hFF && m != 23'd0) begin
                    spec_res_next = QNAN;
                    spec_err_next = 1'b1;
                end else if (e == 8'hFF && !s) begin
                    spec_res_next = 32'h7F800000;
                end else if (s) begin
                    spec_res_next = QNAN;
                    spec_err_next = 1'b1;
                end else begin
                    // Odd exponent halves the radicand so the exponent halves exactly
                    spec_next  = 1'b0;
                    rad_next   = (RAD_W'({sig, 24'b0}) >> e[0]) << (RAD_W - 48);
                    exp_next   = 8'((9'(e) + 9'd126 + 9'(e[0])) >> 1);
                    q_next     = '0;
                    rem_next   = '0;
                    cnt_next   = '0;
                    state_next = ITER;
                end
            end
            ITER: begin
                if (!trial[REM_W]) begin
                    rem_next = trial[REM_W-1:0];
                    q_next   = {q[ITERS-2:0], 1'b1};
                end else begin
                    rem_next = sh;
                    q_next   = {q[ITERS-2:0], 1'b0};
                end
                rad_next = rad << 2;
                cnt_next = cnt + 1'b1;
                if (cnt == CNT_W'(ITERS - 1)) begin
                    state_next = PACK;
                end
            end
            PACK: begin
                r_o_next   = 1'b1;
                state_next = IDLE;
                if (spec) begin
                    res_next = spec_res;
                    err_next = spec_err;
                end else begin
                    err_next = 1'b0;
`ifdef SQRT_ROUND_NEAREST_EN
                    // Leading root bit is always set, so carry out of bit 22 is carry out of bit 23
                    if (rsum[23] && q[ITERS-1]) begin
                        res_next = {1'b0, exp_inc, 23'b0};
                    end else begin
                        res_next = {1'b0, exp_r, rsum[22:0]};
                    end
`else
                    res_next = {1'b0, exp_r, q[22:0]};
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
